// File: rtl/deserializer_stream_if.sv
// Handshake bundle for deserializer_stream: the serial beat input on one side and
// the buffered word output on the other.
interface deserializer_stream_if #(
  parameter int WORD_WIDTH = 24,
  parameter int LANE_WIDTH = 1,
  parameter int OUT_DEPTH  = 2
);
  localparam int LVL_W = $clog2(OUT_DEPTH + 1);

  logic [LANE_WIDTH-1:0] iv_din;
  logic                  i_din_valid;
  logic                  o_din_ready;
  logic [WORD_WIDTH-1:0] ov_dout;
  logic                  o_dout_valid;
  logic                  i_dout_ready;
  logic [LVL_W-1:0]      ov_level;

  modport slave (
    input  iv_din, i_din_valid, i_dout_ready,
    output o_din_ready, ov_dout, o_dout_valid, ov_level
  );

  modport master (
    output iv_din, i_din_valid, i_dout_ready,
    input  o_din_ready, ov_dout, o_dout_valid, ov_level
  );
endinterface

// File: rtl/deserializer_stream.sv
// Serial-to-parallel converter: packs LANE_WIDTH-bit beats into WORD_WIDTH-bit words
// and buffers them in a small first-word-fall-through FIFO.
module deserializer_stream #(
  parameter int WORD_WIDTH = 24,
  parameter int LANE_WIDTH = 1,
  parameter int MSB_FIRST  = 0,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_flush,
  deserializer_stream_if.slave bus
);
  localparam int BEATS = WORD_WIDTH / LANE_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int LVL_W = $clog2(OUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SPACE} state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [WORD_WIDTH-1:0] sr_reg;
  logic [WORD_WIDTH-1:0] merged;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [WORD_WIDTH-1:0] mem [OUT_DEPTH];

  logic full, empty, at_last;
  logic din_ready, beat_acc, push;
  logic dout_valid, pop;

  assign full    = (level_reg == FULL_LVL);
  assign empty   = (level_reg == '0);
  assign at_last = (cnt_reg == LAST_CNT);

  // Ready depends only on registered state, never on the downstream ready.
  assign din_ready  = !i_rst && i_en && !i_flush && (state_reg != WAIT_SPACE) && !(at_last && full);
  assign beat_acc   = din_ready && bus.i_din_valid;
  assign push       = beat_acc && at_last;
  assign dout_valid = !i_rst && i_en && !empty;
  assign pop        = dout_valid && bus.i_dout_ready;

  // The incoming beat is dropped into its lane so the final beat can be pushed directly.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    localparam int POS = (MSB_FIRST != 0) ? (BEATS - 1 - gi) : gi;
    localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
    assign merged[POS*LANE_WIDTH +: LANE_WIDTH] =
      (cnt_reg == IDX) ? bus.iv_din : sr_reg[POS*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sr_reg    <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        sr_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (beat_acc) begin
              if (BEATS > 1) begin
                cnt_reg   <= cnt_reg + CNT_W'(1);
                sr_reg    <= merged;
                state_reg <= FILL;
              end
            end else if (at_last && full) begin
              state_reg <= WAIT_SPACE;
            end
          end
          FILL: begin
            if (beat_acc) begin
              if (at_last) begin
                cnt_reg   <= '0;
                sr_reg    <= '0;
                state_reg <= IDLE;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                sr_reg  <= merged;
              end
            end else if (at_last && full) begin
              state_reg <= WAIT_SPACE;
            end
          end
          WAIT_SPACE: begin
            if (!full) state_reg <= (BEATS > 1) ? FILL : IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= merged;
  end

  assign bus.o_din_ready  = din_ready;
  assign bus.o_dout_valid = dout_valid;
  assign bus.ov_dout      = (i_rst || empty) ? '0 : mem[rd_ptr_reg];
  assign bus.ov_level     = i_rst ? '0 : level_reg;
endmodule
